max7219_spi_serializer: RTL and testbench
=========================================

# max7219_spi_serializer

Serial output stage for the MAX7219 display path. Sits directly downstream of the register-sequencing controller: accepts one 16-bit command word (`{4'b0000, addr[3:0], data[7:0]}`) per valid/ack handshake and shifts it MSB-first onto the MAX7219 three-wire interface (DIN, CLK, LOAD). LOAD rises after the 16th bit so the device latches the word. Only after the LOAD pulse completes does the block acknowledge the next word.

## Interface
Parameters:
- `WORD_SIZE`, 16: bits per frame; fixed by the MAX7219 protocol, must be 16.
- `CLOCK_DIVIDER`, 2: system clocks per SPI half-period; must be ≥1.
- `LOAD_HIGH_CYCLES`, 2: system clocks LOAD is held high after a frame; must be ≥1.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `in_data`  in  WORD_SIZE  command word from the upstream controller.
- `in_valid`  in  1  `in_data` is valid.
- `in_ack`  out  1  word taken this cycle; upstream advances on this edge.
- `spi_clk`  out  1  MAX7219 CLK; the device samples DIN on the rising edge.
- `spi_din`  out  1  MAX7219 DIN.
- `spi_load`  out  1  MAX7219 LOAD/CS; low during shifting; the rising edge latches the frame.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE: `spi_load`=1, `spi_clk`=0.
  - `in_ack` = `in_valid` (combinational, and only in IDLE).
  - At an edge with `in_valid`=1, capture `in_data` into the shift register, clear the bit counter (4 bits) and the divider counter (`$clog2(CLOCK_DIVIDER)`, min 1 bit), and go to SHIFT.
- SHIFT: `spi_load`=0; `spi_din` = shift register MSB.
  - Each bit is a low phase then a high phase of `spi_clk`, each CLOCK_DIVIDER cycles long.
  - At the end of each high phase, shift left by 1 and increment the bit counter.
  - After the high phase of bit 0 (the 16th bit), go to LATCH.
- LATCH: `spi_clk`=0, `spi_load`=1 for LOAD_HIGH_CYCLES cycles, then go to IDLE.
- `in_ack` is 0 in SHIFT and LATCH. `in_data` and `in_valid` are ignored outside IDLE; a change to `in_data` mid-frame does not alter the bits on the line.
- `spi_din` holds its last shifted value in LATCH/IDLE. It is don't-care there but must be deterministic.
- All outputs are registered except `in_ack`.

## Timing
- Reset values (while `reset`=1, asynchronous): state IDLE, `spi_clk`=0, `spi_din`=0, `spi_load`=1, shift register 0, counters 0.
- `in_ack` is forced to 0 while `reset`=1.
- Capture edge T0. From T0+1:
  - `spi_load`=0, and `spi_din`=`in_data[15]`, for the whole first bit.
  - `spi_clk` low for cycles T0+1..T0+D and high for T0+D+1..T0+2D, where D = CLOCK_DIVIDER.
  - `spi_din` changes only on the cycle that `spi_clk` falls, never on a rising `spi_clk`. This gives a setup time of D cycles.
- The SHIFT phase lasts 32·D cycles. LATCH starts at T0+32·D+1, where `spi_load` rises and `spi_clk` is 0.
- IDLE is re-entered at T0+32·D+LOAD_HIGH_CYCLES+1. With `in_valid` held at 1, the next `in_ack` occurs in that cycle.
- Minimum frame period: 32·D + LOAD_HIGH_CYCLES + 1 cycles; 67 with default parameters.
- Exactly 16 rising edges of `spi_clk` per frame, all while `spi_load`=0.
- Reset mid-SHIFT: outputs return immediately to their reset values. The rising `spi_load` then latches a partial word in the device. This is accepted; the upstream stage re-sends from its own reset state.
- `in_valid` rising in LATCH: no ack until IDLE.

## Test plan
- Reset: hold `reset`=1 with `in_valid`=1 → `in_ack`=0, `spi_load`=1, `spi_clk`=0, `spi_din`=0. Release → `in_ack`=1 in the first cycle.
- Single frame, defaults, `in_data`=0x0C01 → DIN sampled at the 16 `spi_clk` rising edges is 0000_1100_0000_0001. `spi_load` is low for exactly 64 cycles, then high; `in_ack` pulses for 1 cycle.
- Back-to-back, `in_valid` held at 1 with the upstream controller attached → acks are exactly 67 cycles apart. Decoded frames give address sequence 0xC, 0xB, 0xA, 0x9, 0x8, …, 0x1, 0x8 with the matching data bytes.
- `CLOCK_DIVIDER`=1, `LOAD_HIGH_CYCLES`=1 → `spi_clk` toggles every cycle, 16 rising edges, period 34 cycles, bits correct.
- Change `in_data` to 0xFFFF one cycle after ack of 0x0A0F → 0x0A0F is still shifted; 0xFFFF is taken only at the next ack.
- Assert `reset` after the 5th `spi_clk` rise → outputs return to their reset values immediately. After release, the next accepted frame is complete and correct.

Source files
------------

// File: rtl/max7219_spi_serializer.sv
// ---------------------------------------------------------------------------
// MaX7219 serial output stage.
//
// Takes one 16-bit command word ({4'b0000, addr[3:0], data[7:0]}) per
// valid/ack handshake from the register-sequencing controller and shifts it
// MSB-first onto the MAX7219 three-wire interface. LOAD is held low while the
// bits go out and rises after the 16th bit so the device latches the word.
// The next word is only acknowledged once the LOAD-high period has finished.
//
// Parameters:
//   WORD_SIZE         bits per frame (the MAX7219 protocol requires 16)
//   CLOCK_DIVIDER     system clocks per spi_clk half-period (>= 1)
//   LOAD_HIGH_CYCLES  system clocks spi_load stays high after a frame (>= 1)
//
// Ports:
//   clock     in   system clock, rising-edge active
//   reset     in   asynchronous, active-high reset
//   in_data   in   command word from the upstream controller
//   in_valid  in   in_data is valid
//   in_ack    out  word taken this cycle (combinational, IDLE only)
//   spi_clk   out  MAX7219 CLK (device samples DIN on the rising edge)
//   spi_din   out  MAX7219 DIN
//   spi_load  out  MAX7219 LOAD/CS (low while shifting, rising edge latches)
// ---------------------------------------------------------------------------
module max7219_spi_serializer #(
  parameter int WORD_SIZE        = 16,
  parameter int CLOCK_DIVIDER    = 2,
  parameter int LOAD_HIGH_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ack,
  output logic                 spi_clk,
  output logic                 spi_din,
  output logic                 spi_load
);

  localparam int DIV_W  = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam int LOAD_W = (LOAD_HIGH_CYCLES > 1) ? $clog2(LOAD_HIGH_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCK_DIVIDER - 1);
  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_HIGH_CYCLES - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(WORD_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } stateType;

  stateType              r_state;
  logic [WORD_SIZE-1:0]  r_shift;
  logic [3:0]            r_bitCnt;
  logic [DIV_W-1:0]      r_divCnt;
  logic                  r_highPhase;
  logic [LOAD_W-1:0]     r_loadCnt;
  logic                  r_spiClk;
  logic                  r_spiLoad;

  stateType              w_stateNext;
  logic [WORD_SIZE-1:0]  w_shiftNext;
  logic [3:0]            w_bitCntNext;
  logic [DIV_W-1:0]      w_divCntNext;
  logic                  w_highPhaseNext;
  logic [LOAD_W-1:0]     w_loadCntNext;
  logic                  w_spiClkNext;
  logic                  w_spiLoadNext;

  // The handshake is only open in IDLE. Reset gates it so the upstream
  // controller never sees an ack while this block is being cleared.
  assign in_ack = (r_state == IDLE) && in_valid && !reset;

  // DIN is driven straight from the shift register MSB, so it is a flop
  // output and only moves when the register is loaded or shifted.
  assign spi_din  = r_shift[WORD_SIZE-1];
  assign spi_clk  = r_spiClk;
  assign spi_load = r_spiLoad;

  // Next-state and next-output logic. Every next value defaults to "hold"
  // so each state only has to spell out what it changes.
  // In SHIFT each bit is a low phase followed by a high phase, each
  // CLOCK_DIVIDER cycles long. The shift happens as spi_clk falls, which
  // gives DIN a full half-period of setup before the next rising edge.
  // The shift is skipped after the final bit so DIN keeps showing bit 0
  // through LATCH and IDLE instead of a shifted-in zero.
  always_comb begin
    w_stateNext     = r_state;
    w_shiftNext     = r_shift;
    w_bitCntNext    = r_bitCnt;
    w_divCntNext    = r_divCnt;
    w_highPhaseNext = r_highPhase;
    w_loadCntNext   = r_loadCnt;
    w_spiClkNext    = r_spiClk;
    w_spiLoadNext   = r_spiLoad;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_stateNext     = SHIFT;
          w_shiftNext     = in_data;
          w_bitCntNext    = '0;
          w_divCntNext    = '0;
          w_highPhaseNext = 1'b0;
          w_spiClkNext    = 1'b0;
          w_spiLoadNext   = 1'b0;
        end
      end

      SHIFT: begin
        if (r_divCnt != DIV_LAST) begin
          w_divCntNext = r_divCnt + 1'b1;
        end else begin
          w_divCntNext = '0;
          if (!r_highPhase) begin
            w_highPhaseNext = 1'b1;
            w_spiClkNext    = 1'b1;
          end else begin
            w_highPhaseNext = 1'b0;
            w_spiClkNext    = 1'b0;
            w_bitCntNext    = r_bitCnt + 4'd1;
            if (r_bitCnt == BIT_LAST) begin
              w_stateNext   = LATCH;
              w_spiLoadNext = 1'b1;
              w_loadCntNext = '0;
            end else begin
              w_shiftNext = {r_shift[WORD_SIZE-2:0], 1'b0};
            end
          end
        end
      end

      LATCH: begin
        if (r_loadCnt == LOAD_LAST) begin
          w_stateNext = IDLE;
        end else begin
          w_loadCntNext = r_loadCnt + 1'b1;
        end
      end

      default: begin
        w_stateNext   = IDLE;
        w_spiClkNext  = 1'b0;
        w_spiLoadNext = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset puts the line into its idle shape
  // (LOAD high, CLK low, DIN low) immediately, even mid-frame; the partial
  // word the device latches then is overwritten by the upstream re-send.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_divCnt    <= '0;
      r_highPhase <= 1'b0;
      r_loadCnt   <= '0;
      r_spiClk    <= 1'b0;
      r_spiLoad   <= 1'b1;
    end else begin
      r_state     <= w_stateNext;
      r_shift     <= w_shiftNext;
      r_bitCnt    <= w_bitCntNext;
      r_divCnt    <= w_divCntNext;
      r_highPhase <= w_highPhaseNext;
      r_loadCnt   <= w_loadCntNext;
      r_spiClk    <= w_spiClkNext;
      r_spiLoad   <= w_spiLoadNext;
    end
  end

endmodule

// File: tb/tb_max7219_spi_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for max7219_spi_serializer.
// Two instances: dut0 with default parameters (D=2, L=2) and dut1 with the
// fastest setting (D=1, L=1). The expected line waveform for every cycle of
// a frame is computed from the cycle offset after the capture edge.
// ---------------------------------------------------------------------------
module tb_max7219_spi_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] data0, data1;
  logic        valid0, valid1;
  logic        ack0, clk0, din0, load0;
  logic        ack1, clk1, din1, load1;

  logic        curSel;
  logic        ackS, clkS, dinS, loadS;

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int lastAck = 0;

  typedef struct {
    logic        sel;
    logic [15:0] word;
    logic        hold;
    logic        chg;
    logic        per;
  } vecType;

  vecType vec [10];

  max7219_spi_serializer dut0 (
    .clock    (clock),
    .reset    (reset),
    .in_data  (data0),
    .in_valid (valid0),
    .in_ack   (ack0),
    .spi_clk  (clk0),
    .spi_din  (din0),
    .spi_load (load0)
  );

  max7219_spi_serializer #(
    .WORD_SIZE        (16),
    .CLOCK_DIVIDER    (1),
    .LOAD_HIGH_CYCLES (1)
  ) dut1 (
    .clock    (clock),
    .reset    (reset),
    .in_data  (data1),
    .in_valid (valid1),
    .in_ack   (ack1),
    .spi_clk  (clk1),
    .spi_din  (din1),
    .spi_load (load1)
  );

  // Free-running clock and a cycle counter used for ack spacing.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Outputs of whichever instance the current test is driving.
  assign ackS  = curSel ? ack1  : ack0;
  assign clkS  = curSel ? clk1  : clk0;
  assign dinS  = curSel ? din1  : din0;
  assign loadS = curSel ? load1 : load0;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected test end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [15:0] d, input logic v);
    if (sel) begin
      data1  = d;
      valid1 = v;
    end else begin
      data0  = d;
      valid0 = v;
    end
  endtask

  // Expected {load, clk, din} at cycle offset k after the capture edge.
  // Bit b occupies cycles 2D*b+1 .. 2D*(b+1); its second half has CLK high.
  function automatic logic [2:0] model(input int k, input int D, input int L, input logic [15:0] w);
    int   b;
    logic hi;
    if (k <= 32 * D) begin
      b  = (k - 1) / (2 * D);
      hi = ((k - 1) % (2 * D)) >= D;
      return {1'b0, hi, w[15 - b]};
    end
    return {1'b1, 1'b0, w[0]};
  endfunction

  // One frame: present the word, check ack, then check every cycle of the
  // frame against the model, decode DIN at each CLK rise, and check that
  // IDLE is re-entered at the right cycle.
  task automatic applyStimulus(input logic sel, input logic [15:0] w, input logic hold,
                               input logic chg, input logic per);
    int          D;
    int          L;
    int          rises;
    logic        prevClk;
    logic [15:0] dec;
    logic [2:0]  exp;
    D       = sel ? 1 : 2;
    L       = sel ? 1 : 2;
    rises   = 0;
    prevClk = 1'b0;
    dec     = '0;
    curSel  = sel;
    drive(sel, w, 1'b1);
    #1;
    checkOutput($sformatf("ack %04h {load,clk,ack}", w), {29'd0, loadS, clkS, ackS}, 32'b101);
    if (per) checkOutput($sformatf("ack period %04h", w), cyc - lastAck, 32 * D + L + 1);
    lastAck = cyc;
    for (int k = 1; k <= 32 * D + L; k++) begin
      @(negedge clock);
      if (k == 1) drive(sel, chg ? 16'hFFFF : w, hold);
      #1;
      exp = model(k, D, L, w);
      checkOutput($sformatf("frame %04h cycle %0d {load,clk,din,ack}", w, k),
                  {28'd0, loadS, clkS, dinS, ackS}, {28'd0, exp, 1'b0});
      if (clkS && !prevClk) begin
        rises++;
        dec = {dec[14:0], dinS};
      end
      prevClk = clkS;
    end
    @(negedge clock);
    #1;
    checkOutput($sformatf("idle %04h {load,clk,ack}", w), {29'd0, loadS, clkS, ackS}, {29'd0, 2'b10, hold});
    checkOutput($sformatf("decoded word %04h", w), {16'd0, dec}, {16'd0, w});
    checkOutput($sformatf("clk rises %04h", w), rises, 16);
  endtask

  initial begin
    logic [15:0] rw;
    logic        rs;
    int          r;
    logic        p;

    vec[0] = '{1'b0, 16'h0C01, 1'b1, 1'b0, 1'b0};
    vec[1] = '{1'b0, 16'h0B07, 1'b1, 1'b0, 1'b1};
    vec[2] = '{1'b0, 16'h0A00, 1'b1, 1'b0, 1'b1};
    vec[3] = '{1'b0, 16'h0900, 1'b1, 1'b0, 1'b1};
    vec[4] = '{1'b0, 16'h0801, 1'b0, 1'b0, 1'b1};
    vec[5] = '{1'b0, 16'h0A0F, 1'b1, 1'b1, 1'b0};
    vec[6] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vec[7] = '{1'b1, 16'h0C01, 1'b1, 1'b0, 1'b0};
    vec[8] = '{1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b1};
    vec[9] = '{1'b0, 16'h0C01, 1'b0, 1'b0, 1'b0};

    // Reset with valid asserted: no ack, idle line shape on both instances.
    reset  = 1'b1;
    curSel = 1'b0;
    drive(1'b0, 16'h0C01, 1'b1);
    drive(1'b1, 16'h0000, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset dut0 {load,clk,din,ack}", {28'd0, load0, clk0, din0, ack0}, 32'b1000);
    checkOutput("reset dut1 {load,clk,din,ack}", {28'd0, load1, clk1, din1, ack1}, 32'b1000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("ack after reset release", {31'd0, ack0}, 32'd1);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vec[i].sel, vec[i].word, vec[i].hold, vec[i].chg, vec[i].per);
    end

    // Reset after the 5th CLK rise, then a full re-sent frame.
    $display("[TB] mid-frame reset");
    curSel = 1'b0;
    drive(1'b0, 16'h0A55, 1'b1);
    @(negedge clock);
    drive(1'b0, 16'h0A55, 1'b0);
    r = 0;
    p = 1'b0;
    for (int n = 0; n < 300 && r < 5; n++) begin
      if (n > 0) @(negedge clock);
      #1;
      if (clk0 && !p) r++;
      p = clk0;
    end
    checkOutput("fifth clk rise seen", r, 5);
    reset  = 1'b1;
    valid0 = 1'b1;
    #1;
    checkOutput("mid-frame reset {load,clk,din,ack}", {28'd0, load0, clk0, din0, ack0}, 32'b1000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("ack after mid-frame reset", {31'd0, ack0}, 32'd1);
    applyStimulus(1'b0, 16'h0A55, 1'b0, 1'b0, 1'b0);

    $display("[TB] random frames");
    repeat (6) begin
      rs = 1'($urandom_range(0, 1));
      rw = 16'($urandom);
      applyStimulus(rs, rw, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
